// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back port arbiter.
package wb_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_e;

  localparam logic [AW-1:0] R0_ADDR = '0;

  function automatic logic is_r0(input logic [AW-1:0] addr);
    return addr == R0_ADDR;
  endfunction

endpackage

// File: rtl/wb_wait_counter.sv
// Saturating count of cycles an MDU request has lost arbitration; clear has priority over increment.
// o_reach_on_inc flags that one more lost cycle brings the count to MAX_WAIT.
module wb_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_reach_on_inc
);

  localparam int CW = 4;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CW{1'b1}})) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_reach_on_inc = (r_cnt == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the WB stage and the MDU; rf_* registered, 1-cycle latency.
// Losing WB sees pipe_stall, losing MDU sees no mdu_ack; WB_CONFLICT_CNT_EN adds a saturating overlap counter.
module wb_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW       = wb_pkg::AW,
  parameter int DW       = wb_pkg::DW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pipe_wr_en,
  input  logic [AW-1:0] pipe_wr_addr,
  input  logic [DW-1:0] pipe_wr_data,
  output logic          pipe_stall,
  input  logic          mdu_req,
  input  logic [AW-1:0] mdu_addr,
  input  logic [DW-1:0] mdu_data,
  output logic          mdu_ack,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          arb_state
`ifdef WB_CONFLICT_CNT_EN
  ,
  output logic [15:0]   conflict_cnt
`endif
);

  import wb_pkg::*;

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic          w_grant_pipe;
  logic          w_grant_mdu;
  logic          w_stall;
  logic          w_mdu_lost;
  logic          w_cnt_clr;
  logic          w_reach_on_inc;
  logic          w_grant_any;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_data;
  logic          w_sel_r0;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;
  logic          r_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Everything is gated by reset_n so the combinational handshakes read 0 while in reset.
  always_comb begin
    w_grant_pipe = 1'b0;
    w_grant_mdu  = 1'b0;
    w_stall      = 1'b0;
    w_mdu_lost   = 1'b0;
    w_state_nxt  = ARB_NORMAL;
    if (reset_n) begin
      if (r_state == ARB_FORCE) begin
        w_grant_mdu = mdu_req;
        w_stall     = pipe_wr_en;
      end else begin
        unique case ({pipe_wr_en, mdu_req})
          2'b10: w_grant_pipe = 1'b1;
          2'b01: w_grant_mdu  = 1'b1;
          2'b11: begin
            if (pipe_wr_addr == mdu_addr) begin
              // MDU op is older; writing it first keeps same-register order intact.
              w_grant_mdu = 1'b1;
              w_stall     = 1'b1;
            end else begin
              w_grant_pipe = 1'b1;
              w_mdu_lost   = 1'b1;
              if (w_reach_on_inc) begin
                w_state_nxt = ARB_FORCE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign w_cnt_clr = w_grant_mdu || !mdu_req || (r_state == ARB_FORCE);

  wb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_cnt (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_clr          (w_cnt_clr),
    .i_inc          (w_mdu_lost),
    .o_reach_on_inc (w_reach_on_inc)
  );

  assign w_grant_any = w_grant_pipe || w_grant_mdu;
  assign w_sel_addr  = w_grant_mdu ? mdu_addr : pipe_wr_addr;
  assign w_sel_data  = w_grant_mdu ? mdu_data : pipe_wr_data;
  assign w_sel_r0    = (w_sel_addr == AW'(R0_ADDR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_grant_any && !w_sel_r0;
      if (w_grant_any) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign pipe_stall = w_stall;
  assign mdu_ack    = w_grant_mdu;
  assign rf_we      = r_we;
  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign arb_state  = r_state;

`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict_cnt <= '0;
    end else if (pipe_wr_en && mdu_req && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inputs change 1ns after the rising edge, outputs are sampled 1ns later.
module tb_wb_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        pipe_wr_en;
  logic [4:0]  pipe_wr_addr;
  logic [31:0] pipe_wr_data;
  logic        pipe_stall;
  logic        mdu_req;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        arb_state;
`ifdef WB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  wb_port_arbiter #(
    .MAX_WAIT (4),
    .AW       (5),
    .DW       (32)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pipe_wr_en   (pipe_wr_en),
    .pipe_wr_addr (pipe_wr_addr),
    .pipe_wr_data (pipe_wr_data),
    .pipe_stall   (pipe_stall),
    .mdu_req      (mdu_req),
    .mdu_addr     (mdu_addr),
    .mdu_data     (mdu_data),
    .mdu_ack      (mdu_ack),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .arb_state    (arb_state)
`ifdef WB_CONFLICT_CNT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic en, input logic [4:0] addr, input logic [31:0] data);
    pipe_wr_en   = en;
    pipe_wr_addr = addr;
    pipe_wr_data = data;
  endtask

  task automatic set_mdu(input logic req, input logic [4:0] addr, input logic [31:0] data);
    mdu_req  = req;
    mdu_addr = addr;
    mdu_data = data;
  endtask

  initial begin
    reset_n = 1'b0;
    set_pipe(1'b1, 5'd4, 32'h1111);
    set_mdu(1'b1, 5'd6, 32'h2222);
    #22;
    check_eq("rst_stall", 32'(pipe_stall), 32'd0);
    check_eq("rst_ack", 32'(mdu_ack), 32'd0);
    check_eq("rst_we", 32'(rf_we), 32'd0);
    check_eq("rst_waddr", 32'(rf_waddr), 32'd0);
    check_eq("rst_wdata", rf_wdata, 32'd0);
    check_eq("rst_state", 32'(arb_state), 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Pipe-only write.
    set_pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check_eq("pipe_stall", 32'(pipe_stall), 32'd0);
    step();
    check_eq("pipe_we", 32'(rf_we), 32'd1);
    check_eq("pipe_waddr", 32'(rf_waddr), 32'd5);
    check_eq("pipe_wdata", rf_wdata, 32'hDEAD_BEEF);
    set_pipe(1'b0, 5'd0, 32'd0);
    step();
    check_eq("pipe_we_1cyc", 32'(rf_we), 32'd0);

    // Different-address conflict: pipe wins 4 cycles, then FORCE.
    set_pipe(1'b1, 5'd3, 32'h33);
    set_mdu(1'b1, 5'd7, 32'h1234);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("cf_ack%0d", i), 32'(mdu_ack), 32'd0);
      check_eq($sformatf("cf_stall%0d", i), 32'(pipe_stall), 32'd0);
      step();
      check_eq($sformatf("cf_waddr%0d", i), 32'(rf_waddr), 32'd3);
    end
    check_eq("force_state", 32'(arb_state), 32'd1);
    check_eq("force_ack", 32'(mdu_ack), 32'd1);
    check_eq("force_stall", 32'(pipe_stall), 32'd1);
    step();
    check_eq("force_we", 32'(rf_we), 32'd1);
    check_eq("force_waddr", 32'(rf_waddr), 32'd7);
    check_eq("force_wdata", rf_wdata, 32'h1234);
    set_mdu(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("resume_state", 32'(arb_state), 32'd0);
    check_eq("resume_stall", 32'(pipe_stall), 32'd0);
    step();
    check_eq("resume_waddr", 32'(rf_waddr), 32'd3);
    check_eq("resume_wdata", rf_wdata, 32'h33);
    set_pipe(1'b0, 5'd0, 32'd0);
    step();

    // Same address: MDU first, pipe stalled one cycle.
    set_pipe(1'b1, 5'd9, 32'hA);
    set_mdu(1'b1, 5'd9, 32'hB);
    #1;
    check_eq("same_stall", 32'(pipe_stall), 32'd1);
    check_eq("same_ack", 32'(mdu_ack), 32'd1);
    step();
    check_eq("same_first", rf_wdata, 32'hB);
    check_eq("same_first_we", 32'(rf_we), 32'd1);
    set_mdu(1'b0, 5'd0, 32'd0);
    #1;
    check_eq("same_unstall", 32'(pipe_stall), 32'd0);
    step();
    check_eq("same_second", rf_wdata, 32'hA);
    check_eq("same_second_addr", 32'(rf_waddr), 32'd9);
    set_pipe(1'b0, 5'd0, 32'd0);
    step();

    // r0 write consumes the port but never asserts rf_we.
    set_mdu(1'b1, 5'd0, 32'h55);
    #1;
    check_eq("r0_ack", 32'(mdu_ack), 32'd1);
    step();
    check_eq("r0_we", 32'(rf_we), 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    step();

    // Reset asserted in the FORCE cycle.
    set_pipe(1'b1, 5'd3, 32'h44);
    set_mdu(1'b1, 5'd7, 32'h99);
    repeat (4) step();
    check_eq("rf_force_state", 32'(arb_state), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("rf_rst_we", 32'(rf_we), 32'd0);
    check_eq("rf_rst_state", 32'(arb_state), 32'd0);
    check_eq("rf_rst_ack", 32'(mdu_ack), 32'd0);
    check_eq("rf_rst_stall", 32'(pipe_stall), 32'd0);
    set_pipe(1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("rf_post_we0", 32'(rf_we), 32'd0);
    step();
    check_eq("rf_post_we1", 32'(rf_we), 32'd0);
    check_eq("rf_post_state", 32'(arb_state), 32'd0);

    // MDU flush mid-wait clears the count: 3 losses, drop, then 3 more must not force.
    set_pipe(1'b1, 5'd2, 32'h22);
    set_mdu(1'b1, 5'd8, 32'h88);
    repeat (3) step();
    set_mdu(1'b0, 5'd8, 32'h88);
    step();
    check_eq("flush_we", 32'(rf_we), 32'd1);
    check_eq("flush_waddr", 32'(rf_waddr), 32'd2);
`ifdef WB_CONFLICT_CNT_EN
    check_eq("conflict_cnt", 32'(conflict_cnt), 32'd3);
`endif
    set_mdu(1'b1, 5'd8, 32'h88);
    repeat (3) step();
    check_eq("flush_no_force", 32'(arb_state), 32'd0);
    step();
    check_eq("flush_force", 32'(arb_state), 32'd1);
    set_pipe(1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
    step();
    check_eq("flush_force_we", 32'(rf_we), 32'd0);
    check_eq("flush_force_waddr", 32'(rf_waddr), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between two sources. The first is the pipeline write-back stage, whose already-selected result arrives from the MemToReg mux. The second is the multi-cycle multiply/divide unit (MDU). Outputs are registered and drive the register file directly. The block stalls the pipeline when the MDU must take the port.

Parameters:
MAX_WAIT, 4, cycles an MDU request may lose arbitration before it is forced through (1..15)
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
pipe_wr_en  in  1  WB stage has a result to write this cycle
pipe_wr_addr  in  AW  WB destination register
pipe_wr_data  in  DW  WB result (write-back mux output)
pipe_stall  out  1  combinational; WB stage must hold its inputs this cycle
mdu_req  in  1  MDU result pending; held until acked
mdu_addr  in  AW  MDU destination register
mdu_data  in  DW  MDU result
mdu_ack  out  1  combinational; MDU request consumed at this rising edge
rf_we  out  1  registered register-file write enable
rf_waddr  out  AW  registered write address
rf_wdata  out  DW  registered write data
arb_state  out  1  0 = NORMAL, 1 = FORCE (debug)

Behaviour:
- Reset (async, reset_n low): rf_we=0, rf_waddr=0, rf_wdata=0, state=NORMAL, wait_cnt=0.
- Combinational outputs are 0 while in reset, whatever the inputs.
- Latency: a source granted in cycle N appears on rf_* in cycle N+1 and lasts exactly one cycle.
- Only one source is granted per cycle.
- The ungranted pipeline sees pipe_stall=1. An ungranted MDU sees mdu_ack=0.
- Grant rules in NORMAL:
  - Only pipe_wr_en: grant pipe.
  - Only mdu_req: grant MDU, mdu_ack=1.
  - Both, different addresses: grant pipe, mdu_ack=0, wait_cnt++.
  - Both, same address: grant MDU (older op), pipe_stall=1. This preserves write order.
  - Neither: rf_we=0 next cycle.
- Starvation: when wait_cnt reaches MAX_WAIT with mdu_req still high, state moves to FORCE.
- FORCE lasts one cycle:
  - MDU granted, mdu_ack=1, pipe_stall=pipe_wr_en.
  - Next state is NORMAL and wait_cnt is cleared.
- wait_cnt clears on any MDU grant. It also clears when mdu_req is low.
- Register 0: a grant with address 0 still consumes the port (ack/no stall), but rf_we is forced to 0 the next cycle.
- pipe_stall never depends on rf_* outputs, which avoids a comb loop through the WB stage.
- mdu_req dropped without an ack (MDU flush) clears wait_cnt and returns the block to NORMAL. No write occurs.
- reset_n asserted mid-FORCE aborts the pending write. No rf_we pulse follows reset release.

Optional Feature:
WB_CONFLICT_CNT_EN:
- Defined: adds output conflict_cnt [15:0]. It increments, saturating at 16'hFFFF, in each cycle where both pipe_wr_en and mdu_req are high. It is reset to 0.
- Undefined: the port is absent and no counter logic is built.

Decomposition:
- Shared package wb_pkg holds AW, DW, the arb_state encoding (ARB_NORMAL=1'b0, ARB_FORCE=1'b1) and the R0 address constant.
- One natural sub-module: wb_wait_counter, a saturating wait counter with clear/increment and a reached-MAX_WAIT flag.
- Grant logic and output registers stay in the top.

Test Plan:
- Pipe-only write: pipe_wr_en=1, addr=5, data=32'hDEAD_BEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=DEADBEEF; pipe_stall=0.
- Conflict, different addresses: pipe (addr 3) every cycle, mdu_req (addr 7, data 0x1234) held -> pipe granted 4 cycles, FORCE on 5th with mdu_ack=1 and pipe_stall=1 -> rf writes r7=0x1234 once, then pipe resumes.
- Same address: pipe addr 9 data 0xA, mdu addr 9 data 0xB same cycle -> r9=0xB written first, then r9=0xA; pipe_stall=1 for one cycle.
- r0 suppression: mdu_req addr 0 -> mdu_ack=1, rf_we stays 0.
- Reset during FORCE: drop reset_n in FORCE cycle -> rf_we=0, arb_state=0. After release, with inputs idle, no write occurs.
- With WB_CONFLICT_CNT_EN: 3 overlap cycles -> conflict_cnt=3.
